// File: rtl/bp_resolve_ctrl.sv
// Branch resolution controller: tracks predicted branches in flight, drives predictor
// updates at resolution and generates flush/redirect plus a recovery stall on mispredicts.
module bp_resolve_ctrl #(
    parameter int DEPTH       = 4,
    parameter int PC_W        = 32,
    parameter int RECOVER_CYC = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pred_valid,
    input  logic            pred_taken,
    input  logic [PC_W-1:0] pred_target,
    input  logic [PC_W-1:0] pred_fallthru,
    output logic            pred_ready,
    input  logic            res_valid,
    input  logic            res_taken,
    output logic            bp_update,
    output logic            bp_actual,
    output logic            flush,
    output logic [PC_W-1:0] redirect_pc,
    output logic            empty,
    output logic            res_err,
    output logic [15:0]     branch_cnt,
    output logic [15:0]     mispredict_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int RC_W  = $clog2(RECOVER_CYC + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RECOVER_CYC);
    localparam logic [15:0]      CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [RC_W-1:0]   r_rec_cnt;

    logic              r_fifo_taken [DEPTH];
    logic [PC_W-1:0]   r_fifo_tgt   [DEPTH];
    logic [PC_W-1:0]   r_fifo_ft    [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic              r_bp_update;
    logic              r_bp_actual;
    logic              r_flush;
    logic [PC_W-1:0]   r_redirect_pc;
    logic              r_res_err;
    logic [15:0]       r_branch_cnt;
    logic [15:0]       r_mispredict_cnt;

    logic              w_pred_ready;
    logic              w_res_acc;
    logic              w_res_rej;
    logic              w_mispred;
    logic              w_push;
    logic              w_head_taken;
    logic [PC_W-1:0]   w_head_tgt;
    logic [PC_W-1:0]   w_head_ft;

    assign w_head_taken = r_fifo_taken[r_rptr];
    assign w_head_tgt   = r_fifo_tgt[r_rptr];
    assign w_head_ft    = r_fifo_ft[r_rptr];

    assign w_pred_ready = (r_state == ST_RUN) && (r_count < DEPTH_C);
    assign w_res_acc    = res_valid && (r_state == ST_RUN) && (r_count != '0);
    assign w_res_rej    = res_valid && !w_res_acc;
    assign w_mispred    = w_res_acc && (res_taken != w_head_taken);
    // A push coinciding with a mispredict belongs to the wrong path and is dropped.
    assign w_push       = pred_valid && w_pred_ready && !w_mispred;

    // FSM next-state: enter RECOVER on mispredict, leave when the stall window expires.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_mispred) begin
                    w_state_nxt = ST_RECOVER;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RECOVER: begin
                if (r_rec_cnt <= RC_W'(1)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_RECOVER;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // FSM state and recovery counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_rec_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mispred) begin
                r_rec_cnt <= RC_LOAD;
            end else if ((r_state == ST_RECOVER) && (r_rec_cnt != '0)) begin
                r_rec_cnt <= r_rec_cnt - RC_W'(1);
            end
        end
    end

    // FIFO entry storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_taken[i] <= 1'b0;
                r_fifo_tgt[i]   <= '0;
                r_fifo_ft[i]    <= '0;
            end
        end else if (w_push) begin
            r_fifo_taken[r_wptr] <= pred_taken;
            r_fifo_tgt[r_wptr]   <= pred_target;
            r_fifo_ft[r_wptr]    <= pred_fallthru;
        end
    end

    // FIFO pointers and occupancy; a mispredict discards every in-flight entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_mispred) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_res_acc) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_res_acc);
        end
    end

    // Registered predictor-update and front-end redirect strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bp_update   <= 1'b0;
            r_bp_actual   <= 1'b0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_bp_update <= w_res_acc;
            r_bp_actual <= w_res_acc && res_taken;
            r_flush     <= w_mispred;
            if (w_mispred) begin
                r_redirect_pc <= res_taken ? w_head_tgt : w_head_ft;
            end else begin
                r_redirect_pc <= '0;
            end
        end
    end

    // Sticky protocol error and saturating statistics counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_res_err        <= 1'b0;
            r_branch_cnt     <= 16'h0000;
            r_mispredict_cnt <= 16'h0000;
        end else begin
            r_res_err <= r_res_err || w_res_rej;
            if (w_res_acc && (r_branch_cnt != CNT_MAX)) begin
                r_branch_cnt <= r_branch_cnt + 16'h0001;
            end
            if (w_mispred && (r_mispredict_cnt != CNT_MAX)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 16'h0001;
            end
        end
    end

    assign pred_ready     = w_pred_ready;
    assign empty          = (r_count == '0);
    assign bp_update      = r_bp_update;
    assign bp_actual      = r_bp_actual;
    assign flush          = r_flush;
    assign redirect_pc    = r_redirect_pc;
    assign res_err        = r_res_err;
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule
